// File: rtl/audio_clk_gen.sv
// Multi-channel NCO clock-enable generator, held off until PLL lock has been stable.
// Optional phase-align strobe (sync port) enabled by defining AUDIO_CLKGEN_SYNC_EN.
module audio_clk_gen #(
    parameter int unsigned CH        = 2,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned LOCK_SYNC = 2,
    parameter int unsigned LOCK_WAIT = 1024,
    localparam int unsigned SEL_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             inc_wr,
    input  logic [SEL_W-1:0] inc_sel,
    input  logic [ACC_W-1:0] inc_data,
`ifdef AUDIO_CLKGEN_SYNC_EN
    input  logic             sync,
`endif
    output logic             ready,
    output logic [CH-1:0]    ce,
    output logic [CH-1:0]    tog
);

    localparam int unsigned CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_e;

    logic [LOCK_SYNC-1:0] lock_sync_q, lock_sync_d;
    logic                 lock_s;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [ACC_W-1:0]     acc_q   [CH];
    logic [ACC_W-1:0]     acc_d   [CH];
    logic [ACC_W-1:0]     inc_a_q [CH];
    logic [ACC_W-1:0]     inc_a_d [CH];
    logic [ACC_W-1:0]     inc_p_q [CH];
    logic [ACC_W-1:0]     inc_p_d [CH];
    logic [CH-1:0]        pv_q, pv_d;
    logic [CH-1:0]        ce_q, ce_d;
    logic [CH-1:0]        tog_q, tog_d;
    logic                 sync_c;
    logic                 run_c;

`ifdef AUDIO_CLKGEN_SYNC_EN
    assign sync_c = sync;
`else
    assign sync_c = 1'b0;
`endif

    assign lock_sync_d = {lock_sync_q[LOCK_SYNC-2:0], pll_lock};
    assign lock_s      = lock_sync_q[LOCK_SYNC-1];

    // Lock qualification FSM; ready lags the state by one registered cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = SETTLE;
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
        ready_d = (state_q == RUN);
    end

    // Channels step only while ready stays high; leaving RUN clears phase and outputs.
    assign run_c = ready_q & ready_d;

    always_comb begin
        logic [ACC_W:0] sum;
        logic           wr_hit;
        for (int i = 0; i < int'(CH); i++) begin
            acc_d[i]   = acc_q[i];
            inc_a_d[i] = inc_a_q[i];
            inc_p_d[i] = inc_p_q[i];
            pv_d[i]    = pv_q[i];
            ce_d[i]    = 1'b0;
            tog_d[i]   = tog_q[i];
            sum        = '0;
            wr_hit     = inc_wr && (32'(inc_sel) == 32'(i));

            if (!ready_d) begin
                acc_d[i] = '0;
                tog_d[i] = 1'b0;
            end else if (run_c && sync_c) begin
                acc_d[i] = '0;
                tog_d[i] = 1'b0;
                if (pv_q[i]) begin
                    inc_a_d[i] = inc_p_q[i];
                    pv_d[i]    = 1'b0;
                end
            end else if (run_c) begin
                sum      = {1'b0, acc_q[i]} + {1'b0, inc_a_q[i]};
                acc_d[i] = sum[ACC_W-1:0];
                ce_d[i]  = sum[ACC_W];
                if (sum[ACC_W]) begin
                    tog_d[i] = ~tog_q[i];
                    if (pv_q[i]) begin
                        inc_a_d[i] = inc_p_q[i];
                        pv_d[i]    = 1'b0;
                    end
                end
            end

            // A write landing on the swap cycle becomes the next pending value.
            if (wr_hit) begin
                if ((inc_a_q[i] == '0) || !ready_q) begin
                    inc_a_d[i] = inc_data;
                end else begin
                    inc_p_d[i] = inc_data;
                    pv_d[i]    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            pv_q        <= '0;
            ce_q        <= '0;
            tog_q       <= '0;
            for (int i = 0; i < int'(CH); i++) begin
                acc_q[i]   <= '0;
                inc_a_q[i] <= '0;
                inc_p_q[i] <= '0;
            end
        end else begin
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            pv_q        <= pv_d;
            ce_q        <= ce_d;
            tog_q       <= tog_d;
            for (int i = 0; i < int'(CH); i++) begin
                acc_q[i]   <= acc_d[i];
                inc_a_q[i] <= inc_a_d[i];
                inc_p_q[i] <= inc_p_d[i];
            end
        end
    end

    assign ready = ready_q;
    assign ce    = ce_q;
    assign tog   = tog_q;

endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed bench for audio_clk_gen: lock sequencing, NCO rates, pending-increment swap, sync.
module tb_audio_clk_gen;

    localparam int unsigned CH        = 3;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned LOCK_SYNC = 2;
    localparam int unsigned LOCK_WAIT = 16;
    localparam int unsigned SEL_W     = 2;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             pll_lock = 1'b0;
    logic             inc_wr   = 1'b0;
    logic [SEL_W-1:0] inc_sel  = '0;
    logic [ACC_W-1:0] inc_data = '0;
    logic             sync     = 1'b0;
    logic             ready;
    logic [CH-1:0]    ce;
    logic [CH-1:0]    tog;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_clk_gen #(
        .CH(CH), .ACC_W(ACC_W), .LOCK_SYNC(LOCK_SYNC), .LOCK_WAIT(LOCK_WAIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_lock(pll_lock),
        .inc_wr(inc_wr),
        .inc_sel(inc_sel),
        .inc_data(inc_data),
`ifdef AUDIO_CLKGEN_SYNC_EN
        .sync(sync),
`endif
        .ready(ready),
        .ce(ce),
        .tog(tog)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [SEL_W-1:0] sel, input logic [ACC_W-1:0] d);
        inc_wr   = 1'b1;
        inc_sel  = sel;
        inc_data = d;
        step(1);
        inc_wr   = 1'b0;
    endtask

    initial begin
        int  bad_ce0, bad_tog0, bad_ce1, n_ce1, wide1, bad2, bad_win, bad2w;
        logic exp_ce0, exp_tog0, prev1;
        bad_ce0 = 0; bad_tog0 = 0; bad_ce1 = 0; n_ce1 = 0; wide1 = 0;
        bad2 = 0; bad_win = 0; bad2w = 0;
        exp_tog0 = 1'b0; prev1 = 1'b0;

        step(3);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_ce", 64'(ce), 64'd0);
        chk("reset_tog", 64'(tog), 64'd0);

        rst_n = 1'b1;
        step(1);
        wr(2'd0, 32'h4000_0000);
        wr(2'd1, 32'h5555_5556);

        pll_lock = 1'b1;
        step(19);
        chk("ready_early", 64'(ready), 64'd0);
        step(1);
        chk("ready_rise", 64'(ready), 64'd1);
        chk("ce_at_ready", 64'(ce), 64'd0);

        for (int k = 1; k <= 3000; k++) begin
            step(1);
            exp_ce0 = ((k % 4) == 0);
            if (exp_ce0) exp_tog0 = ~exp_tog0;
            if (ce[0] !== exp_ce0) bad_ce0++;
            if (tog[0] !== exp_tog0) bad_tog0++;
            if (ce[1] !== ((k % 3) == 0)) bad_ce1++;
            if (ce[1]) n_ce1++;
            if (ce[1] && prev1) wide1++;
            prev1 = ce[1];
            if (ce[2] || tog[2]) bad2++;
        end
        chk("ch0_ce_every4", 64'(bad_ce0), 64'd0);
        chk("ch0_tog_period8", 64'(bad_tog0), 64'd0);
        chk("ch1_ce_every3", 64'(bad_ce1), 64'd0);
        chk("ch1_count_1000", 64'(n_ce1), 64'd1000);
        chk("ch1_width1", 64'(wide1), 64'd0);
        chk("ch2_idle", 64'(bad2), 64'd0);

        // offset 3001: mid-period double write, then an out-of-range write
        step(1);
        chk("ch0_mid_period", 64'(ce[0]), 64'd0);
        wr(2'd0, 32'h2000_0000);
        wr(2'd0, 32'h8000_0000);
        wr(2'd3, 32'h1000_0000);
        chk("ch0_old_spacing", 64'(ce[0]), 64'd1);
        for (int k = 3005; k <= 3024; k++) begin
            step(1);
            if (ce[0] !== ((k % 2) == 0)) bad_win++;
            if (ce[2] || tog[2]) bad2w++;
        end
        chk("ch0_new_spacing2", 64'(bad_win), 64'd0);
        chk("sel_out_of_range", 64'(bad2w), 64'd0);

        pll_lock = 1'b0;
        step(3);
        chk("ready_hold", 64'(ready), 64'd1);
        step(1);
        chk("ready_fall", 64'(ready), 64'd0);
        chk("ce_fall", 64'(ce), 64'd0);
        chk("tog_fall", 64'(tog), 64'd0);

        // increments survive loss of lock; phase restarts from zero
        pll_lock = 1'b1;
        step(19);
        chk("relock_early", 64'(ready), 64'd0);
        step(1);
        chk("relock_ready", 64'(ready), 64'd1);
        step(1);
        chk("relock_ce0_r1", 64'(ce[0]), 64'd0);
        step(1);
        chk("relock_ce0_r2", 64'(ce[0]), 64'd1);
        chk("relock_tog0_r2", 64'(tog[0]), 64'd1);

`ifdef AUDIO_CLKGEN_SYNC_EN
        wr(2'd0, 32'h4000_0000);
        wr(2'd1, 32'h1000_0000);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("sync_tog", 64'(tog[1:0]), 64'd0);
        chk("sync_ce", 64'(ce), 64'd0);
        step(3);
        chk("sync_ce0_s3", 64'(ce[0]), 64'd0);
        step(1);
        chk("sync_ce0_s4", 64'(ce[0]), 64'd1);
        step(11);
        chk("sync_ce1_s15", 64'(ce[1]), 64'd0);
        step(1);
        chk("sync_ce1_s16", 64'(ce[1]), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
